// File: rtl/n101_icb_regbank_rsp.sv
// ICB responder for a bank of NREG 32-bit control registers with byte-masked writes.
// Optional build macro N101_REGBANK_LOCK_EN adds a sticky write-lock in reg[NREG-1] bit 0.
module n101_icb_regbank_rsp #(
  parameter int NREG = 8,
  parameter int AW   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 icb_cmd_valid,
  output logic                 icb_cmd_ready,
  input  logic [AW-1:0]        icb_cmd_addr,
  input  logic                 icb_cmd_read,
  input  logic [31:0]          icb_cmd_wdata,
  input  logic [3:0]           icb_cmd_wmask,
  output logic                 icb_rsp_valid,
  input  logic                 icb_rsp_ready,
  output logic [31:0]          icb_rsp_rdata,
  output logic                 icb_rsp_err,
  output logic [NREG*32-1:0]   reg_q,
  output logic [NREG-1:0]      reg_wr_pulse
);

  localparam int IW = AW - 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [NREG-1:0]   r_wr_pulse;
  logic [31:0]       r_regs [NREG];

  logic [IW-1:0]     w_idx;
  logic              w_in_range;
  logic              w_accept;
  logic              w_write;
  logic              w_blocked;
  logic              w_err;
  logic [NREG-1:0]   w_sel;
  logic [NREG-1:0]   w_wr_en;
  logic [31:0]       w_rd_val;
  logic [31:0]       w_rsp_rdata_nxt;
  logic [31:0]       w_reg_nxt [NREG];
  logic              w_unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_idx         = icb_cmd_addr[AW-1:2];
  assign w_unused_addr = ^icb_cmd_addr[1:0];
  assign w_in_range    = (w_idx < IW'(NREG));
  assign icb_cmd_ready = ~r_rsp_valid | icb_rsp_ready;
  assign w_accept      = icb_cmd_valid & icb_cmd_ready;
  assign w_write       = w_accept & ~icb_cmd_read;

`ifdef N101_REGBANK_LOCK_EN
  // Once the lock bit is set only the lock register itself stays writable.
  assign w_blocked = r_regs[NREG-1][0] & (w_idx != IW'(NREG-1));
`else
  assign w_blocked = 1'b0;
`endif

  assign w_err           = ~w_in_range | (~icb_cmd_read & w_blocked);
  assign w_wr_en         = {NREG{w_write & ~w_blocked}} & w_sel;
  assign w_rsp_rdata_nxt = (icb_cmd_read & w_in_range) ? w_rd_val : 32'h0;

  // Address decode and read-data mux.
  always_comb begin
    w_sel    = '0;
    w_rd_val = 32'h0;
    for (int i = 0; i < NREG; i++) begin
      w_sel[i] = (w_idx == IW'(i));
      w_rd_val = w_rd_val | (w_sel[i] ? r_regs[i] : 32'h0);
    end
  end

  // Candidate next value of every register for a write this cycle.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_reg_nxt[i] = merge_bytes(r_regs[i], icb_cmd_wdata, icb_cmd_wmask);
    end
`ifdef N101_REGBANK_LOCK_EN
    w_reg_nxt[NREG-1][0] = r_regs[NREG-1][0] | (icb_cmd_wmask[0] & icb_cmd_wdata[0]);
`endif
  end

  // Register storage, updated on the accept edge of an allowed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= w_reg_nxt[i];
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Response FSM with registered response outputs and write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_wr_pulse  <= '0;
    end else begin
      r_wr_pulse <= w_wr_en;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_err;
          end else begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= r_rsp_rdata;
            r_rsp_err   <= r_rsp_err;
          end
        end
        ST_RSP: begin
          if (w_accept) begin
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_err;
          end else if (icb_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
          end else begin
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_rsp_rdata;
            r_rsp_err   <= r_rsp_err;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign icb_rsp_valid = r_rsp_valid;
  assign icb_rsp_rdata = r_rsp_rdata;
  assign icb_rsp_err   = r_rsp_err;
  assign reg_wr_pulse  = r_wr_pulse;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_q
    assign reg_q[32*gi +: 32] = r_regs[gi];
  end

endmodule
